// File: rtl/host_reg_bank.sv
// host_reg_bank: parametrised CPU-side register bank with config, read-only status
// and self-clearing pulse registers, an Ack/Err handshake, per-register write strobes
// and hardware clear inputs. Exactly one access is performed per chip-select assertion.
module host_reg_bank #(
  parameter int                             NUM_REGS   = 35,
  parameter int                             DATA_W     = 16,
  parameter int                             ADDR_W     = 8,
  parameter int                             ADDR_LSB   = 1,
  parameter logic [NUM_REGS*DATA_W-1:0]     RST_VAL    = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]            PULSE_MASK = '0
) (
  input  logic                              Clk_reg,
  input  logic                              Reset_n,
  input  logic                              CSB,
  input  logic                              WRB,
  input  logic [ADDR_W-1:0]                 CA,
  input  logic [DATA_W-1:0]                 CD_in,
  output logic [DATA_W-1:0]                 CD_out,
  output logic                              Ack,
  output logic                              Err,
  output logic [NUM_REGS*DATA_W-1:0]        Reg_q,
  output logic [NUM_REGS-1:0]               Wr_strobe,
  input  logic [NUM_REGS*DATA_W-1:0]        Status_in,
  input  logic [NUM_REGS-1:0]               Hw_clr
);

  localparam int IDX_W = ADDR_W - ADDR_LSB;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                     r_state;
  logic [DATA_W-1:0]          r_cdOut;
  logic                       r_ack;
  logic                       r_err;
  logic [NUM_REGS-1:0]        r_wrStrobe;
  logic [NUM_REGS*DATA_W-1:0] r_regQ;

  logic [IDX_W-1:0]           w_idx;
  logic                       w_valid;
  logic                       w_start;
  logic                       w_isRo;
  logic [DATA_W-1:0]          w_rdData;
  logic [NUM_REGS-1:0]        w_wrHit;

  assign w_idx   = CA[ADDR_W-1:ADDR_LSB];
  assign w_valid = (int'(w_idx) < NUM_REGS);
  assign w_start = (r_state == IDLE) && !CSB;

  // The low byte-address bits never take part in the register decode.
  generate
    if (ADDR_LSB > 0) begin : g_lsb
      logic w_unusedLsb;
      assign w_unusedLsb = ^CA[ADDR_LSB-1:0];
    end
  endgenerate

  // Decode the selected register: read data, read-only flag and the write hit vector.
  always_comb begin
    w_isRo   = 1'b0;
    w_rdData = '0;
    w_wrHit  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_valid && (w_idx == IDX_W'(i))) begin
        w_isRo     = RO_MASK[i];
        w_rdData   = RO_MASK[i] ? Status_in[i*DATA_W +: DATA_W] : r_regQ[i*DATA_W +: DATA_W];
        w_wrHit[i] = w_start && !WRB && !RO_MASK[i];
      end
    end
  end

  // Register storage: CPU write beats hardware clear; pulse registers fall back to reset value.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      r_regQ <= RST_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i]) begin
          r_regQ[i*DATA_W +: DATA_W] <= RST_VAL[i*DATA_W +: DATA_W];
        end else if (w_wrHit[i]) begin
          r_regQ[i*DATA_W +: DATA_W] <= CD_in;
        end else if (Hw_clr[i] || PULSE_MASK[i]) begin
          r_regQ[i*DATA_W +: DATA_W] <= RST_VAL[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Access FSM: one access on the first select edge, then hold Ack until select is released.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_cdOut    <= '0;
      r_wrStrobe <= '0;
    end else begin
      r_wrStrobe <= '0;
      case (r_state)
        IDLE: begin
          if (!CSB) begin
            r_state    <= HOLD;
            r_ack      <= 1'b1;
            r_wrStrobe <= w_wrHit;
            if (WRB) begin
              r_cdOut <= w_valid ? w_rdData : '0;
              r_err   <= !w_valid;
            end else begin
              r_cdOut <= '0;
              r_err   <= !(w_valid && !w_isRo);
            end
          end
        end
        HOLD: begin
          if (CSB) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cdOut <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign CD_out    = r_cdOut;
  assign Ack       = r_ack;
  assign Err       = r_err;
  assign Reg_q     = r_regQ;
  assign Wr_strobe = r_wrStrobe;

endmodule
